// File: rtl/vga_capture_pkg.sv
// Shared VGA timing defaults, capture FSM states and the framebuffer address map
// used by both the display controller and the frame capture block.
package vga_capture_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_WIN      = 200;

  // Wide enough for a saturated pixel count and any line count of the default timing.
  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    WAIT_ACT,
    CAPTURE,
    FINISH
  } capture_state_t;

  function automatic logic [15:0] fb_addr(input logic [15:0] row,
                                          input logic [15:0] col,
                                          input logic [15:0] win = 16'(DEF_WIN));
    return row + col * win;
  endfunction

endpackage

// File: rtl/vga_frame_capture_sync_edge.sv
// Samples one active-low sync on the pixel enable and flags its edges against the
// previous sample; the idle (deasserted) level is the reset value.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync_in,
  output logic rise,
  output logic fall
);

  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b1;
    end else if (pix_en) begin
      sync_q <= sync_in;
    end
  end

  assign rise = pix_en & sync_in & ~sync_q;
  assign fall = pix_en & ~sync_in & sync_q;

endmodule

// File: rtl/vga_frame_capture.sv
// Captures the top-left WIN x WIN window of one VGA frame into the framebuffer,
// recovering pixel/line position from the sync edges. Single-cycle write port.
module vga_frame_capture
  import vga_capture_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_BP     = DEF_V_BP,
  parameter int WIN      = DEF_WIN
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_en,
  input  logic           h_sync,
  input  logic           v_sync,
  input  logic [7:0]     red,
  input  logic [7:0]     green,
  input  logic [7:0]     blue,
  input  logic           arm,
  output logic           wr_en,
  output logic [15:0]    wr_addr,
  output logic [31:0]    wr_data,
  output logic           busy,
  output logic           done,
  output logic           frame_err,
  output capture_state_t dbg_state
);

  localparam logic [CNT_W-1:0] HB       = CNT_W'(H_BP);
  localparam logic [CNT_W-1:0] HA_END   = CNT_W'(H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] HT       = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] VB       = CNT_W'(V_BP);
  localparam logic [CNT_W-1:0] VA_END   = CNT_W'(V_BP + V_ACTIVE);
  localparam logic [CNT_W-1:0] WN       = CNT_W'(WIN);
  // A window larger than the active area is clipped, so the final pixel moves in.
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(((WIN < H_ACTIVE) ? WIN : H_ACTIVE) - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(((WIN < V_ACTIVE) ? WIN : V_ACTIVE) - 1);

  capture_state_t   state;
  logic             vr_seen;
  logic             h_rise, h_fall, v_rise, v_fall;
  logic [CNT_W-1:0] pc, lc, pc_nx, lc_nx, col, row;
  logic             col_ok, row_ok, pix_hit, last_px, overrun, sync_err;
  logic             go_cap, capturing;

  sync_edge u_hs (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync_in(h_sync),
    .rise   (h_rise),
    .fall   (h_fall)
  );

  sync_edge u_vs (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync_in(v_sync),
    .rise   (v_rise),
    .fall   (v_fall)
  );

  // Position of the pixel being sampled on this pix_en (post-update counter values).
  always_comb begin
    pc_nx = pc;
    lc_nx = lc;
    if (h_rise) begin
      pc_nx = '0;
    end else if (pc != HT) begin
      pc_nx = pc + 1'b1;
    end
    if (v_rise) begin
      lc_nx = '0;
    end else if (h_rise && (lc != '1)) begin
      lc_nx = lc + 1'b1;
    end
  end

  always_comb begin
    col       = pc_nx - HB;
    row       = lc_nx - VB;
    col_ok    = (pc_nx >= HB) && (pc_nx < HA_END) && (col < WN);
    row_ok    = (lc_nx >= VB) && (lc_nx < VA_END) && (row < WN);
    pix_hit   = pix_en && col_ok && row_ok;
    last_px   = (col == COL_LAST) && (row == ROW_LAST);
    overrun   = pix_en && (pc_nx == HT);
    sync_err  = v_fall || overrun;
    go_cap    = (state == WAIT_ACT) && pix_en && (v_rise || vr_seen) && (lc_nx == VB);
    capturing = (state == CAPTURE) || go_cap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
      lc <= '0;
    end else if (pix_en) begin
      pc <= pc_nx;
      lc <= lc_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vr_seen   <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state     <= WAIT_VS;
            busy      <= 1'b1;
            frame_err <= 1'b0;
          end
        end
        WAIT_VS: begin
          // The v_sync fall marks a clean frame start; anything before it is discarded.
          if (v_fall) begin
            state   <= WAIT_ACT;
            vr_seen <= 1'b0;
          end
        end
        WAIT_ACT, CAPTURE: begin
          if (sync_err) begin
            frame_err <= 1'b1;
            state     <= WAIT_VS;
          end else begin
            if (v_rise) vr_seen <= 1'b1;
            if (go_cap) state <= CAPTURE;
            if (capturing && pix_hit) begin
              wr_en   <= 1'b1;
              wr_addr <= fb_addr(16'(row), 16'(col), 16'(WIN));
              wr_data <= {8'h00, blue, green, red};
              if (last_px) state <= FINISH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed/randomized bench for vga_frame_capture in a reduced geometry; expected
// framebuffer writes come from a per-frame image and the window address map.
module tb_vga_frame_capture;
  import vga_capture_pkg::*;

  localparam int HA  = 8;
  localparam int HBP = 2;
  localparam int HT  = 12;
  localparam int VA  = 6;
  localparam int VBP = 1;
  localparam int W   = 4;
  localparam int VT  = 9;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, arm_main, arm_mon, arm;
  logic           pix_en, h_sync, v_sync;
  logic [7:0]     red, green, blue;
  logic           wr_en, busy, done, frame_err;
  logic [15:0]    wr_addr;
  logic [31:0]    wr_data;
  capture_state_t dbg_state;

  assign arm = arm_main | arm_mon;

  vga_frame_capture #(
    .H_ACTIVE(HA), .H_BP(HBP), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BP(VBP), .WIN(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_en   (pix_en),
    .h_sync   (h_sync),
    .v_sync   (v_sync),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .arm      (arm),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [47:0] exp_q[$];
  logic [7:0]  img_r [VA][HA];
  logic [7:0]  img_g [VA][HA];
  logic [7:0]  img_b [VA][HA];
  int compared    = 0;
  int mismatched  = 0;
  int done_cnt    = 0;
  int cyc         = 0;
  int last_wr_cyc = -10;
  int rst_k       = 0;
  bit arm_on_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // write / done monitor
  always @(negedge clk) begin
    logic [47:0] e;
    if (arm_mon) arm_mon = 1'b0;
    if (rst_n && wr_en) begin
      if (arm_on_last && exp_q.size() == 1) arm_mon = 1'b1;
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e[47:32]));
        check("wr_data", 64'(wr_data), 64'(e[31:0]));
      end
      last_wr_cyc = cyc;
    end
    if (rst_n && done) begin
      check("done_latency", 64'(cyc - last_wr_cyc), 64'd1);
      check("busy_with_done", 64'(busy), 64'd0);
      done_cnt++;
    end
  end

  // driver tasks
  task automatic drive_pix(input logic hs, input logic vs,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(posedge clk);
    #1;
    h_sync = hs; v_sync = vs; red = r; green = g; blue = b;
    pix_en = 1'b1;
    @(posedge clk);
    #1;
    pix_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic pulse_arm();
    @(posedge clk);
    #1 arm_main = 1'b1;
    @(posedge clk);
    #1 arm_main = 1'b0;
  endtask

  task automatic new_image();
    for (int r = 0; r < VA; r++)
      for (int c = 0; c < HA; c++) begin
        img_r[r][c] = 8'($urandom);
        img_g[r][c] = 8'($urandom);
        img_b[r][c] = 8'($urandom);
      end
  endtask

  // Window pixels in raster order, addressed column-major; only the first n are expected.
  task automatic push_exp(input int n);
    int k;
    k = 0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        if (k < n)
          exp_q.push_back({16'(r + c * W), 8'h00, img_b[r][c], img_g[r][c], img_r[r][c]});
        k++;
      end
  endtask

  // One frame: back porch line, active lines, front porch line, v_sync line.
  task automatic send_frame(input int abort_line, input int stuck_line, input int arm_line);
    logic vs_line, hs;
    for (int l = 0; l < VT; l++) begin
      vs_line = (l == VT - 1) || (l == abort_line);
      for (int p = 0; p < HT; p++) begin
        if (l == arm_line && p == 0) pulse_arm();
        hs = (l == stuck_line) ? 1'b0 : (p != HT - 1);
        if (!vs_line && l >= VBP && l < VBP + VA && p >= HBP && p < HBP + HA)
          drive_pix(hs, 1'b1, img_r[l-VBP][p-HBP], img_g[l-VBP][p-HBP], img_b[l-VBP][p-HBP]);
        else
          drive_pix(hs, !vs_line, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      if (l == abort_line) break;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arm_main = 1'b0; arm_mon = 1'b0;
    pix_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
    red = '0; green = '0; blue = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // arm mid-frame: nothing until the next v_sync fall, then a full window
    new_image();
    send_frame(-1, -1, 3);
    check("a_busy_armed", 64'(busy), 64'd1);
    check("a_state_wait_act", 64'(dbg_state), 64'(WAIT_ACT));
    new_image(); push_exp(16);
    send_frame(-1, -1, -1);
    check("a_all_writes", 64'(exp_q.size()), 64'd0);
    check("a_done_cnt", 64'(done_cnt), 64'd1);
    check("a_busy_after", 64'(busy), 64'd0);
    check("a_frame_err", 64'(frame_err), 64'd0);

    // early v_sync fall after row 2
    check("b_busy_before_arm", 64'(busy), 64'd0);
    pulse_arm();
    check("b_busy_after_arm", 64'(busy), 64'd1);
    send_frame(-1, -1, -1);
    new_image(); push_exp(12);
    send_frame(VBP + 3, -1, -1);
    check("b_frame_err", 64'(frame_err), 64'd1);
    check("b_state_wait_vs", 64'(dbg_state), 64'(WAIT_VS));
    check("b_partial_writes", 64'(exp_q.size()), 64'd0);
    send_frame(-1, -1, -1);
    new_image(); push_exp(16);
    send_frame(-1, -1, -1);
    check("b_all_writes", 64'(exp_q.size()), 64'd0);
    check("b_done_cnt", 64'(done_cnt), 64'd2);
    check("b_frame_err_sticky", 64'(frame_err), 64'd1);

    // h_sync stuck low for a whole line
    pulse_arm();
    check("c_frame_err_cleared", 64'(frame_err), 64'd0);
    send_frame(-1, -1, -1);
    new_image(); push_exp(4);
    send_frame(-1, VBP + 1, -1);
    check("c_frame_err", 64'(frame_err), 64'd1);
    check("c_partial_writes", 64'(exp_q.size()), 64'd0);
    check("c_no_done", 64'(done_cnt), 64'd2);
    new_image(); push_exp(16);
    send_frame(-1, -1, -1);
    check("c_retry_writes", 64'(exp_q.size()), 64'd0);
    check("c_done_cnt", 64'(done_cnt), 64'd3);

    // reset during the 7th write
    pulse_arm();
    send_frame(-1, -1, -1);
    new_image(); push_exp(7);
    fork
      send_frame(-1, -1, -1);
      begin
        rst_k = 0;
        for (int i = 0; i < 4000 && rst_k < 7; i++) begin
          @(negedge clk);
          if (wr_en) rst_k++;
        end
        check("d_reached_7th_write", 64'(rst_k), 64'd7);
        #1 rst_n = 1'b0;
        #1;
        check("d_rst_wr_en", 64'(wr_en), 64'd0);
        check("d_rst_busy", 64'(busy), 64'd0);
        check("d_rst_done", 64'(done), 64'd0);
        check("d_rst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    check("d_seven_writes", 64'(exp_q.size()), 64'd0);
    check("d_no_done", 64'(done_cnt), 64'd3);
    pulse_arm();
    send_frame(-1, -1, -1);
    new_image(); push_exp(16);
    send_frame(-1, -1, -1);
    check("d_recover_writes", 64'(exp_q.size()), 64'd0);
    check("d_done_cnt", 64'(done_cnt), 64'd4);

    // arm while busy and together with the final write is ignored
    pulse_arm();
    send_frame(-1, -1, 3);
    check("e_state_wait_act", 64'(dbg_state), 64'(WAIT_ACT));
    new_image(); push_exp(16);
    arm_on_last = 1'b1;
    send_frame(-1, -1, -1);
    arm_on_last = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("e_all_writes", 64'(exp_q.size()), 64'd0);
    check("e_one_done", 64'(done_cnt), 64'd5);
    check("e_busy_low", 64'(busy), 64'd0);
    check("e_state_idle", 64'(dbg_state), 64'(IDLE));
    new_image();
    send_frame(-1, -1, -1);
    check("e_no_rearm_done", 64'(done_cnt), 64'd5);
    check("e_idle_after", 64'(dbg_state), 64'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Receive-side counterpart of the VGA display path: samples a VGA stream (h_sync, v_sync, 8-bit R/G/B) on the pixel enable and tracks horizontal/vertical position from the sync edges. It writes the top-left 200x200 window of one frame into the framebuffer through a single-cycle write port. The framebuffer address map and pixel word packing are identical to those the display controller reads (addr = row + col*200; data[7:0]=R, [15:8]=G, [23:16]=B). It sits beside the Memory stage as a second framebuffer writer, used for loopback self-test of the display output.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_BP, 48, pixel enables from h_sync deassertion to first visible pixel
- H_TOTAL, 800, pixel enables per line (overrun limit)
- V_ACTIVE, 480, visible lines per frame
- V_BP, 33, lines from v_sync deassertion to first visible line
- WIN, 200, captured window edge (rows and cols < WIN)
- clk  in  1  system clock (same clock as the pipeline)
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle pulse per VGA pixel (clock_vga rate)
- h_sync, v_sync  in  1  active-low syncs
- red, green, blue  in  8 each  pixel colour
- arm  in  1  pulse: capture next complete frame
- wr_en  out  1  framebuffer write strobe
- wr_addr  out  16  row + col*WIN
- wr_data  out  32  {8'h00, blue, green, red}
- busy  out  1  armed or capturing
- done  out  1  one-cycle pulse, frame captured
- frame_err  out  1  sticky until next arm; sync error seen

## Operation
- Sync inputs are registered once on pix_en. Rise and fall pulses come from the previous sample. All other logic advances only on pix_en, except arm, which is sampled every clk.
- Pixel counter pc: cleared on h_sync rise (deassertion), else +1 per pix_en, saturating at H_TOTAL.
- Line counter lc: cleared on v_sync rise, else +1 per h_sync rise.
- col = pc - H_BP, valid when H_BP <= pc < H_BP+H_ACTIVE. row = lc - V_BP, valid when V_BP <= lc < V_BP+V_ACTIVE.
- FSM states: IDLE, WAIT_VS, WAIT_ACT, CAPTURE, FINISH.
  - IDLE: arm -> WAIT_VS. Clears frame_err.
  - WAIT_VS: wait for v_sync fall. Discards any partial frame in progress at arm time -> WAIT_ACT.
  - WAIT_ACT: v_sync rise starts lc. Transition when lc = V_BP -> CAPTURE.
  - CAPTURE: a pixel is written when col < WIN and row < WIN. When row = WIN-1 and col = WIN-1 have been written -> FINISH.
  - FINISH: done pulse -> IDLE.
- Errors, in WAIT_ACT or CAPTURE:
  - v_sync fall arrives before the window is complete: set frame_err and go to WAIT_VS (retry on the next frame).
  - pc reaches H_TOTAL with no h_sync rise: set frame_err and go to WAIT_VS.
- arm while busy is ignored. Any arm in IDLE restarts cleanly.
- Windows wider than the active area (WIN > H_ACTIVE or WIN > V_ACTIVE) are clipped to the active area. In that case FINISH is entered at the end of the last active line.
- Address arithmetic is 16-bit unsigned. The maximum is 199 + 199*200 = 39999, so no wrap.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, frame_err=0, FSM=IDLE, pc=lc=0.
- wr_en is registered. It is high for exactly one clk, the cycle after the pix_en cycle that sampled the pixel, with wr_addr and wr_data valid in that cycle.
- There is no backpressure. The memory accepts one write per clk, and pix_en is at most every second clk.
- Exactly WIN*WIN writes per successful frame, in order: row-major in time, column-major in address.
- done is asserted 1 clk after the last wr_en.
- busy goes high the clk after arm and goes low together with done.
- Reset asserted mid-capture: all outputs go to reset values immediately. There is no partial done.
- Simultaneous h_sync rise and v_sync rise on the same pix_en: lc clears to 0 and pc clears to 0.

## Structure
- Package vga_capture_pkg holds:
  - the timing default constants, shared with the display controller;
  - the state enum capture_state_t;
  - the function fb_addr(row, col) = row + col*WIN.
- One sub-module, sync_edge, instantiated twice: registers a sync on pix_en and emits rise/fall pulses. It has the same clk and reset.

## Test plan
- Reduced geometry (H_ACTIVE=8, H_BP=2, H_TOTAL=12, V_ACTIVE=6, V_BP=1, WIN=4), pixel value = {row, col} pattern:
  - arm mid-frame -> no writes until the next v_sync fall.
  - Then 16 writes, with addr 0,4,8,12,1,5,… and matching RGB.
  - done 1 clk after the 16th write.
- Same geometry, v_sync fall injected after row 2 -> frame_err=1, FSM back to WAIT_VS. The following full frame yields 16 writes and done; frame_err stays 1 until the next arm.
- h_sync held low for a whole line (pc reaches 12) -> frame_err=1 and no further writes that frame.
- reset low during the 7th write -> wr_en, busy, and done are 0 in the same cycle. After release, arm gives a full 16-write capture.
- Default parameters, display controller looped back with a known framebuffer -> captured 40000 words equal the source, last wr_addr=39999.
- arm pulsed while busy and together with the final write -> ignored. Exactly one done, and busy drops with it.
